// File: rtl/bus_decoder6502_pkg.sv
// -----------------------------------------------------------------------------
// bus_decoder6502_pkg
// Shared definitions for the 6502 bus decoder:
//   - sequencer state encoding (IDLE / WAIT)
//   - wait-state counter width
//   - clog2 helper used to size the encoded region index
//   - default base / mask / wait-state constants for the standard system map
//     (region 0 = ROM 0x0xxx, 1 = IO 0x20xx, 2 = RAM 0xExxx, 3 = vectors 0xFFFC-F)
// -----------------------------------------------------------------------------
package bus_decoder6502_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   localparam int WAIT_CNT_W = 4;

   localparam logic [63:0] DEF_REGION_BASE = {16'hFFFC, 16'hE000, 16'h2000, 16'h0000};
   localparam logic [63:0] DEF_REGION_MASK = {16'hFFFC, 16'hF000, 16'hFF00, 16'hF000};
   localparam logic [15:0] DEF_WAIT_STATES = {4'd0, 4'd0, 4'd1, 4'd0};

   // Number of bits needed to encode values 0..n-1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/bus_decoder6502_region_match.sv
// -----------------------------------------------------------------------------
// region_match
// Purely combinational base/mask address matcher with fixed priority.
//   addr     in   ADDR_WIDTH   address to decode
//   hit      out  NUM_REGIONS  one-hot winning region (all zero when unmapped)
//   idx      out  IDX_W        encoded index of the winning region
//   any_hit  out  1            at least one region matched
// Region i matches when (addr & MASK_i) == BASE_i; the lowest index wins.
// -----------------------------------------------------------------------------
module region_match
   import bus_decoder6502_pkg::*;
#(
   parameter int                              NUM_REGIONS = 4,
   parameter int                              ADDR_WIDTH  = 16,
   parameter int                              IDX_W       = 2,
   parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE = DEF_REGION_BASE[NUM_REGIONS*ADDR_WIDTH-1:0],
   parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK = DEF_REGION_MASK[NUM_REGIONS*ADDR_WIDTH-1:0]
) (
   input  logic [ADDR_WIDTH-1:0]  addr,
   output logic [NUM_REGIONS-1:0] hit,
   output logic [IDX_W-1:0]       idx,
   output logic                   any_hit
);

   // Scan from the highest index down so a lower-index match overwrites
   // any higher-index one, giving lowest-index priority.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      hit     = '0;
      idx     = '0;
      any_hit = 1'b0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if ((addr & REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
            hit     = '0;
            hit[i]  = 1'b1;
            idx     = IDX_W'(i);
            any_hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_decoder6502.sv
// -----------------------------------------------------------------------------
// bus_decoder6502
// Address decoder and bus sequencer between a 6502-family CPU and up to eight
// synchronous memory/IO regions, with per-region wait states, address hold
// during stalls, latency-aligned read return and unmapped-access flagging.
//   clk           in   1                       system clock (posedge)
//   reset         in   1                       synchronous active-high reset
//   cpu_addr      in   ADDR_WIDTH              CPU address
//   cpu_we        in   1                       1 = write, 0 = read
//   cpu_req       in   1                       access request
//   cpu_ready     out  1                       access accepted on req & ready
//   cpu_rvalid    out  1                       one-cycle read-data-valid pulse
//   cpu_rdata     out  DATA_WIDTH              read data (held when not valid)
//   mem_addr      out  ADDR_WIDTH              address broadcast to all regions
//   region_sel    out  NUM_REGIONS             one-hot region select
//   region_we     out  NUM_REGIONS             one-hot write strobe
//   region_rdata  in   NUM_REGIONS*DATA_WIDTH  per-region read data (1-cycle latency)
//   bus_err       out  1                       one-cycle pulse after an unmapped access
//   err_addr      out  ADDR_WIDTH              address of the last unmapped access
// Optional (macro BUS_ERR_IRQ_EN):
//   err_clr       in   1                       clears err_irq (wins over a set)
//   err_irq       out  1                       sticky error flag; freezes err_addr
// -----------------------------------------------------------------------------
module bus_decoder6502
   import bus_decoder6502_pkg::*;
#(
   parameter int                                NUM_REGIONS   = 4,
   parameter int                                ADDR_WIDTH    = 16,
   parameter int                                DATA_WIDTH    = 8,
   parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE   = DEF_REGION_BASE[NUM_REGIONS*ADDR_WIDTH-1:0],
   parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_MASK   = DEF_REGION_MASK[NUM_REGIONS*ADDR_WIDTH-1:0],
   parameter logic [NUM_REGIONS*WAIT_CNT_W-1:0] WAIT_STATES   = DEF_WAIT_STATES[NUM_REGIONS*WAIT_CNT_W-1:0],
   parameter logic [DATA_WIDTH-1:0]             UNMAPPED_DATA = 8'h00
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [ADDR_WIDTH-1:0]             cpu_addr,
   input  logic                              cpu_we,
   input  logic                              cpu_req,
   output logic                              cpu_ready,
   output logic                              cpu_rvalid,
   output logic [DATA_WIDTH-1:0]             cpu_rdata,
   output logic [ADDR_WIDTH-1:0]             mem_addr,
   output logic [NUM_REGIONS-1:0]            region_sel,
   output logic [NUM_REGIONS-1:0]            region_we,
   input  logic [NUM_REGIONS*DATA_WIDTH-1:0] region_rdata,
   output logic                              bus_err,
   output logic [ADDR_WIDTH-1:0]             err_addr
`ifdef BUS_ERR_IRQ_EN
   ,
   input  logic                              err_clr,
   output logic                              err_irq
`endif
);

   localparam int IDX_W = (NUM_REGIONS > 1) ? clog2(NUM_REGIONS) : 1;

   logic [NUM_REGIONS-1:0] hit;
   logic [IDX_W-1:0]       hit_idx;
   logic                   any_hit;
   logic [WAIT_CNT_W-1:0]  hit_ws;

   logic [0:0]             state;
   logic [WAIT_CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]       lat_idx;
   logic                   lat_we;
   logic                   lat_hit;
   logic [ADDR_WIDTH-1:0]  lat_addr;
   logic [NUM_REGIONS-1:0] lat_sel;
   logic [DATA_WIDTH-1:0]  rdata_hold;
   logic [DATA_WIDTH-1:0]  sel_rdata;
   logic                   err_frozen;

   region_match #(
      .NUM_REGIONS (NUM_REGIONS),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .IDX_W       (IDX_W),
      .REGION_BASE (REGION_BASE),
      .REGION_MASK (REGION_MASK)
   ) u_match (
      .addr    (cpu_addr),
      .hit     (hit),
      .idx     (hit_idx),
      .any_hit (any_hit)
   );

   assign hit_ws    = WAIT_STATES[int'(hit_idx)*WAIT_CNT_W +: WAIT_CNT_W];
   assign sel_rdata = region_rdata[int'(lat_idx)*DATA_WIDTH +: DATA_WIDTH];

`ifdef BUS_ERR_IRQ_EN
   assign err_frozen = err_irq;

   always_ff @(posedge clk) begin
      if (reset)        err_irq <= 1'b0;
      else if (err_clr) err_irq <= 1'b0;
      else if (bus_err) err_irq <= 1'b1;
   end
`else
   assign err_frozen = 1'b0;
`endif

   // During WAIT the bus keeps presenting the latched access so slow regions
   // see a stable address/select; the write strobe is only ever a single pulse.
   always_comb begin
      cpu_ready  = (state == ST_IDLE);
      mem_addr   = cpu_addr;
      region_sel = '0;
      region_we  = '0;
      if (state == ST_WAIT) begin
         mem_addr   = lat_addr;
         region_sel = lat_sel;
      end else if (cpu_req) begin
         region_sel = hit;
         if (cpu_we && !reset) region_we = hit;
      end
   end

   // Region data arrives one cycle after the access is presented, so the
   // return mux is combinational on the latched index during the rvalid cycle.
   always_comb begin
      cpu_rdata = rdata_hold;
      if (cpu_rvalid) cpu_rdata = lat_hit ? sel_rdata : UNMAPPED_DATA;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         lat_idx    <= '0;
         lat_we     <= 1'b0;
         lat_hit    <= 1'b0;
         lat_addr   <= '0;
         lat_sel    <= '0;
         cpu_rvalid <= 1'b0;
         bus_err    <= 1'b0;
         err_addr   <= '0;
         rdata_hold <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register reading pre-edge values.
         cpu_rvalid <= 1'b0;
         bus_err    <= 1'b0;
         if (cpu_rvalid) rdata_hold <= cpu_rdata;
         case (state)
            ST_IDLE: begin
               if (cpu_req) begin
                  lat_idx  <= hit_idx;
                  lat_we   <= cpu_we;
                  lat_hit  <= any_hit;
                  lat_addr <= cpu_addr;
                  lat_sel  <= hit;
                  if (!any_hit) begin
                     bus_err    <= 1'b1;
                     cpu_rvalid <= !cpu_we;
                     if (!err_frozen) err_addr <= cpu_addr;
                  end else if (hit_ws == '0) begin
                     cpu_rvalid <= !cpu_we;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= hit_ws;
                  end
               end
            end
            default: begin
               cnt <= cnt - WAIT_CNT_W'(1);
               if (cnt == WAIT_CNT_W'(1)) begin
                  state      <= ST_IDLE;
                  cpu_rvalid <= !lat_we;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_decoder6502.sv
// -----------------------------------------------------------------------------
// tb_bus_decoder6502
// Directed bench for bus_decoder6502. A second instance (dut_p) remaps region 3
// onto 0xE000 so the RAM/vector overlap exercises lowest-index priority.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_bus_decoder6502;

   logic        clk;
   logic        reset;
   logic [15:0] cpu_addr;
   logic        cpu_we;
   logic        cpu_req;
   logic [31:0] region_rdata;

   logic        cpu_ready,  p_cpu_ready;
   logic        cpu_rvalid, p_cpu_rvalid;
   logic [7:0]  cpu_rdata,  p_cpu_rdata;
   logic [15:0] mem_addr,   p_mem_addr;
   logic [3:0]  region_sel, p_region_sel;
   logic [3:0]  region_we,  p_region_we;
   logic        bus_err,    p_bus_err;
   logic [15:0] err_addr,   p_err_addr;
`ifdef BUS_ERR_IRQ_EN
   logic        err_clr;
   logic        err_irq, p_err_irq;
`endif

   int n_pass;
   int n_checks;

   bus_decoder6502 dut (
      .clk          (clk),
      .reset        (reset),
      .cpu_addr     (cpu_addr),
      .cpu_we       (cpu_we),
      .cpu_req      (cpu_req),
      .cpu_ready    (cpu_ready),
      .cpu_rvalid   (cpu_rvalid),
      .cpu_rdata    (cpu_rdata),
      .mem_addr     (mem_addr),
      .region_sel   (region_sel),
      .region_we    (region_we),
      .region_rdata (region_rdata),
      .bus_err      (bus_err),
      .err_addr     (err_addr)
`ifdef BUS_ERR_IRQ_EN
      ,
      .err_clr      (err_clr),
      .err_irq      (err_irq)
`endif
   );

   bus_decoder6502 #(
      .REGION_BASE ({16'hE000, 16'hE000, 16'h2000, 16'h0000})
   ) dut_p (
      .clk          (clk),
      .reset        (reset),
      .cpu_addr     (cpu_addr),
      .cpu_we       (cpu_we),
      .cpu_req      (cpu_req),
      .cpu_ready    (p_cpu_ready),
      .cpu_rvalid   (p_cpu_rvalid),
      .cpu_rdata    (p_cpu_rdata),
      .mem_addr     (p_mem_addr),
      .region_sel   (p_region_sel),
      .region_we    (p_region_we),
      .region_rdata (region_rdata),
      .bus_err      (p_bus_err),
      .err_addr     (p_err_addr)
`ifdef BUS_ERR_IRQ_EN
      ,
      .err_clr      (err_clr),
      .err_irq      (p_err_irq)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   // Advance to the next falling edge; the caller then drives inputs.
   task automatic next_cycle;
      @(negedge clk);
   endtask

   task automatic drive(input logic req, input logic we, input logic [15:0] addr);
      cpu_req  = req;
      cpu_we   = we;
      cpu_addr = addr;
      #1;
   endtask

   initial begin
      n_pass       = 0;
      n_checks     = 0;
      reset        = 1'b1;
      cpu_req      = 1'b0;
      cpu_we       = 1'b0;
      cpu_addr     = 16'h0000;
      region_rdata = {8'hC3, 8'h5A, 8'h3C, 8'hA5};
`ifdef BUS_ERR_IRQ_EN
      err_clr      = 1'b0;
`endif

      // ---- reset state; write strobe suppressed while reset is high
      next_cycle; drive(1'b1, 1'b1, 16'h0010);
      check("rst_we_gated", region_we, 4'b0000);
      next_cycle; drive(1'b0, 1'b0, 16'h0000);
      check("rst_ready", cpu_ready, 1'b1);
      check("rst_rvalid", cpu_rvalid, 1'b0);
      check("rst_bus_err", bus_err, 1'b0);
      check("rst_err_addr", err_addr, 16'h0000);
      check("rst_rdata", cpu_rdata, 8'h00);
      reset = 1'b0;

      // ---- ROM read, zero wait states
      next_cycle; drive(1'b1, 1'b0, 16'h0010);
      check("rom_sel", region_sel, 4'b0001);
      check("rom_mem_addr", mem_addr, 16'h0010);
      check("rom_ready", cpu_ready, 1'b1);
      next_cycle; drive(1'b0, 1'b0, 16'h0010);
      check("rom_rvalid", cpu_rvalid, 1'b1);
      check("rom_rdata", cpu_rdata, 8'hA5);
      check("rom_ready_after", cpu_ready, 1'b1);
      check("idle_no_sel", region_sel, 4'b0000);
      next_cycle; region_rdata[7:0] = 8'h11; drive(1'b0, 1'b0, 16'h0010);
      check("rom_rvalid_pulse", cpu_rvalid, 1'b0);
      check("rdata_hold", cpu_rdata, 8'hA5);

      // ---- IO read, one wait state, address held while cpu_addr moves
      next_cycle; drive(1'b1, 1'b0, 16'h2001);
      check("io_sel", region_sel, 4'b0010);
      check("io_ready_accept", cpu_ready, 1'b1);
      next_cycle; drive(1'b1, 1'b0, 16'h0010);
      check("io_ready_wait", cpu_ready, 1'b0);
      check("io_addr_hold", mem_addr, 16'h2001);
      check("io_sel_hold", region_sel, 4'b0010);
      check("io_rvalid_wait", cpu_rvalid, 1'b0);
      next_cycle; drive(1'b0, 1'b0, 16'h0010);
      check("io_ready_back", cpu_ready, 1'b1);
      check("io_rvalid", cpu_rvalid, 1'b1);
      check("io_rdata", cpu_rdata, 8'h3C);

      // ---- RAM write then back-to-back read of the same address
      next_cycle; drive(1'b1, 1'b1, 16'hE123);
      check("ram_we", region_we, 4'b0100);
      check("ram_sel_w", region_sel, 4'b0100);
      next_cycle; drive(1'b1, 1'b0, 16'hE123);
      check("ram_we_once", region_we, 4'b0000);
      check("ram_wr_no_rvalid", cpu_rvalid, 1'b0);
      check("ram_ready_b2b", cpu_ready, 1'b1);
      next_cycle; drive(1'b0, 1'b0, 16'hE123);
      check("ram_rvalid", cpu_rvalid, 1'b1);
      check("ram_rdata", cpu_rdata, 8'h5A);

      // ---- unmapped read
      next_cycle; drive(1'b1, 1'b0, 16'h4000);
      check("unm_sel", region_sel, 4'b0000);
      check("unm_we", region_we, 4'b0000);
      next_cycle; drive(1'b0, 1'b0, 16'h4000);
      check("unm_bus_err", bus_err, 1'b1);
      check("unm_err_addr", err_addr, 16'h4000);
      check("unm_rvalid", cpu_rvalid, 1'b1);
      check("unm_rdata", cpu_rdata, 8'h00);
      check("unm_no_stall", cpu_ready, 1'b1);
      next_cycle; drive(1'b0, 1'b0, 16'h4000);
      check("unm_err_pulse", bus_err, 1'b0);

      // ---- vector area hits region 3; overlap priority on the remapped instance
      next_cycle; drive(1'b1, 1'b0, 16'hFFFD);
      check("vec_sel", region_sel, 4'b1000);
      check("vec_sel_remap", p_region_sel, 4'b0000);
      next_cycle; drive(1'b1, 1'b0, 16'hE001);
      check("vec_rdata", cpu_rdata, 8'hC3);
      check("prio_sel", p_region_sel, 4'b0100);
      next_cycle; drive(1'b0, 1'b0, 16'h0000);
      check("prio_rvalid", p_cpu_rvalid, 1'b1);
      check("prio_rdata", p_cpu_rdata, 8'h5A);

      // ---- reset during the WAIT cycle of an IO read
      next_cycle; drive(1'b1, 1'b0, 16'h2001);
      next_cycle; reset = 1'b1; drive(1'b0, 1'b0, 16'h2001);
      check("abort_in_wait", cpu_ready, 1'b0);
      next_cycle; reset = 1'b0; drive(1'b0, 1'b0, 16'h2001);
      check("abort_ready", cpu_ready, 1'b1);
      check("abort_rvalid", cpu_rvalid, 1'b0);
      check("abort_bus_err", bus_err, 1'b0);
      check("abort_err_addr", err_addr, 16'h0000);
      next_cycle; drive(1'b0, 1'b0, 16'h2001);
      check("abort_no_late_rvalid", cpu_rvalid, 1'b0);

`ifdef BUS_ERR_IRQ_EN
      // ---- sticky error capture
      check("irq_rst", err_irq, 1'b0);
      next_cycle; drive(1'b1, 1'b0, 16'h5000);
      next_cycle; drive(1'b0, 1'b0, 16'h5000);
      check("irq_err1", bus_err, 1'b1);
      next_cycle; drive(1'b1, 1'b0, 16'h6000);
      check("irq_set", err_irq, 1'b1);
      next_cycle; drive(1'b0, 1'b0, 16'h6000);
      check("irq_err2", bus_err, 1'b1);
      check("irq_first_addr", err_addr, 16'h5000);
      next_cycle; err_clr = 1'b1; drive(1'b0, 1'b0, 16'h6000);
      check("irq_still_set", err_irq, 1'b1);
      next_cycle; err_clr = 1'b0; drive(1'b0, 1'b0, 16'h6000);
      check("irq_cleared", err_irq, 1'b0);
      check("irq_addr_kept", err_addr, 16'h5000);
      next_cycle; drive(1'b1, 1'b0, 16'h7000);
      next_cycle; err_clr = 1'b1; drive(1'b0, 1'b0, 16'h7000);
      check("irq_new_addr", err_addr, 16'h7000);
      next_cycle; err_clr = 1'b0; drive(1'b0, 1'b0, 16'h7000);
      check("irq_clr_priority", err_irq, 1'b0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bus_decoder6502.md
Name: bus_decoder6502

Overview:
- Parametrised address decoder and bus sequencer between a CPU (8-bit-workshop 6502 family) and N synchronous memory/IO regions.
- Replaces fixed hard-coded address muxing with:
  - per-region base/mask matching,
  - per-region wait states with a ready/stall handshake,
  - address hold during stalls,
  - a latency-aligned read-data return.
- Flags accesses to unmapped addresses.

Parameters:
- NUM_REGIONS, 4, number of decoded regions (1..8).
- ADDR_WIDTH, 16, CPU address width.
- DATA_WIDTH, 8, data width.
- REGION_BASE, {16'hFFFC,16'hE000,16'h2000,16'h0000}, packed NUM_REGIONS*ADDR_WIDTH bases; region 0 in the LSBs.
- REGION_MASK, {16'hFFFC,16'hF000,16'hFF00,16'hF000}, packed match masks.
- WAIT_STATES, {4'd0,4'd0,4'd1,4'd0}, packed 4-bit stall count per region (0..15).
- UNMAPPED_DATA, 8'h00, read data returned for unmapped addresses.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  ADDR_WIDTH  CPU address.
- cpu_we  in  1  1=write, 0=read.
- cpu_req  in  1  access request.
- cpu_ready  out  1  access accepted when cpu_req&cpu_ready.
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid.
- cpu_rdata  out  DATA_WIDTH  read return data.
- mem_addr  out  ADDR_WIDTH  address to all regions.
- region_sel  out  NUM_REGIONS  one-hot select of the active region.
- region_we  out  NUM_REGIONS  one-hot write strobe.
- region_rdata  in  NUM_REGIONS*DATA_WIDTH  packed sync read data, 1-cycle latency.
- bus_err  out  1  one-cycle pulse on an unmapped access.
- err_addr  out  ADDR_WIDTH  address of the last unmapped access.

Behaviour:
- Match rule:
  - Region i hits when (cpu_addr & MASK_i) == BASE_i.
  - Lowest index wins on overlap.
  - No hit = unmapped.
- FSM states: IDLE, WAIT.
- cpu_ready = (state==IDLE), combinational.
- Accept cycle (IDLE, cpu_req=1):
  - mem_addr = cpu_addr.
  - region_sel = hit vector (combinational).
  - region_we = region_sel & cpu_we.
  - Latch region index, we, addr, and hit flag.
- W=0:
  - Stay IDLE.
  - Next cycle: read asserts cpu_rvalid with cpu_rdata = region_rdata[latched idx]; write asserts no rvalid.
  - Back-to-back accepts every cycle are allowed; rvalid of access n coincides with the accept of n+1.
- W>0:
  - Go to WAIT with counter = W.
  - In WAIT: mem_addr = latched addr, region_sel = latched one-hot, region_we = 0, cpu_ready = 0.
  - Counter decrements each cycle; at counter==1, return to IDLE.
  - The read rvalid and data appear on the first IDLE cycle, i.e. W+1 cycles after accept.
  - Writes also stall W cycles; the strobe is asserted only on the accept cycle.
- Unmapped access:
  - region_sel = 0, region_we = 0, no stall.
  - Next cycle: bus_err = 1 and err_addr updated.
  - A read also gives rvalid = 1 with cpu_rdata = UNMAPPED_DATA.
- cpu_rdata when rvalid = 0: hold the last returned value.
- Reset, including mid-WAIT:
  - state = IDLE, counter = 0, latched idx = 0.
  - cpu_rvalid = 0, bus_err = 0, err_addr = 0, cpu_rdata = 0.
  - No rvalid is issued for an aborted access.
  - region_we = 0 while reset = 1.
- cpu_req = 0 in IDLE: region_sel = 0, region_we = 0, mem_addr = cpu_addr.

Optional Feature:
- Macro: BUS_ERR_IRQ_EN.
- Defined:
  - Adds input err_clr (1) and output err_irq (1).
  - err_irq is set on any bus_err and stays set until err_clr = 1 (clear takes priority over a simultaneous set).
  - err_addr freezes while err_irq = 1 (first-error capture).
  - Reset clears err_irq.
- Undefined: the ports are absent and err_addr tracks every unmapped access.

Decomposition:
- Package bus_decoder6502_pkg holds:
  - state encoding (IDLE/WAIT),
  - wait-counter width (4),
  - function clog2 for the region index width,
  - default base/mask/wait constants for the standard system map.
- Sub-module region_match:
  - Purely combinational.
  - Takes addr, REGION_BASE, REGION_MASK.
  - Outputs the one-hot hit vector, encoded index, and any_hit.

Test Plan:
- Read 0x0010 (ROM, W=0), region_rdata[0]=0xA5 → region_sel=0001 on the accept cycle; next cycle rvalid=1, rdata=0xA5; ready never drops.
- Read 0x2001 (IO, W=1) → ready=0 for exactly 1 cycle; mem_addr held at 0x2001 even when cpu_addr changes; rvalid at accept+2 with region_rdata[1].
- Write 0xE123 data via RAM → region_we=0100 for exactly one cycle; then back-to-back read 0xE123 the next cycle → rvalid pulse one cycle later.
- Read 0x4000 (unmapped) → region_sel=0; next cycle bus_err=1, err_addr=0x4000, rdata=0x00, rvalid=1.
- Read 0xFFFD → hits region 3 (not RAM); check priority with overlapping bases by setting BASE_3=0xE000 and expecting region 2 selected.
- Reset asserted in the WAIT cycle of the IO read → next cycle state IDLE, ready=1, no rvalid, bus_err=0; with BUS_ERR_IRQ_EN, two unmapped reads give err_irq=1 and err_addr = the first address until err_clr.
